blit_param_regs: RTL and testbench
==================================

// Module: blit_param_regs
// PURPOSE
//  Parameter registers and inner-loop counter, directly downstream of the blitter read-parameters state machine.
//  Captures the inner count, step and pattern bytes from the data bus on that machine's registered active-low
//  load strobes (LDINRL/LDSTPL/LDPATL). Runs the inner-loop iteration counter for the inner-loop sequencer.
//  Holds all values until reloaded, so the outer loop can re-run the inner loop without a new parameter read.
// PARAMETERS
//  DW  8  data-bus width; width of inner count, step and pattern registers; counter is DW+1 bits
// PORTS
//  CCLK     in   1     blitter clock, all state changes on rising edge
//  RESETL   in   1     reset, asynchronous, active-low
//  D        in   DW    data bus carrying the parameter byte during the load cycle
//  LDINRL   in   1     active-low load strobe: inner-count store <= D
//  LDSTPL   in   1     active-low load strobe: STEP <= D
//  LDPATL   in   1     active-low load strobe: PATTERN <= D
//  INSTART  in   1     one-cycle pulse from inner sequencer: start an inner loop
//  INSTEP   in   1     one-cycle pulse: one inner iteration completed
//  INCNT    out  DW+1  current remaining iteration count
//  INACT    out  1     high while inner loop running
//  INNERDN  out  1     one-cycle pulse: inner loop finished
//  STEP     out  DW    step register
//  PATTERN  out  DW    pattern register
// BEHAVIOUR
//  - Reset (RESETL low, async): ISTORE=0, STEP=0, PATTERN=0, INCNT=0, state IDLE, INACT=0, INNERDN=0.
//  - Loads: each strobe sampled at the rising edge. A low strobe updates its register on that edge.
//    The value is visible on the outputs the next cycle. Strobes are independent; simultaneous strobes all load.
//  - FSM states: IDLE, RUN, DONE. All outputs are registered.
//  - IDLE + INSTART: INCNT <= {0,ISTORE}.
//    - ISTORE != 0: go to RUN.
//    - ISTORE == 0: see CONFIGURATION.
//    - INSTEP is ignored in IDLE.
//  - RUN: INACT=1. INSTEP with INCNT>1: INCNT <= INCNT-1.
//    INSTEP with INCNT==1: INCNT <= 0, go to DONE.
//  - DONE: INNERDN=1 for exactly this cycle, INACT=0. Unconditional return to IDLE next edge.
//    INSTART in DONE is ignored.
//  - INSTART while in RUN: ignored; the count continues.
//  - INSTART and INSTEP on the same edge in IDLE: start only, no decrement.
//  - LDINRL low while in RUN: updates ISTORE only. The running INCNT is unaffected.
//    The new value applies at the next INSTART.
//  - Same-edge LDINRL and INSTART in IDLE: the counter takes the OLD ISTORE.
//  - Latency: INSTART edge -> INACT=1 the next cycle.
//    Final INSTEP edge -> INNERDN=1 the next cycle.
//  - Reset asserted mid-RUN: immediate return to reset values. No INNERDN pulse.
//  - INCNT never wraps: there is no decrement at 0.
// CONFIGURATION
//  Macro BLIT_INZERO256_EN
//  - Defined: ISTORE==0 at INSTART loads INCNT=2^DW (e.g. 256) and enters RUN (full-length loop).
//  - Undefined: ISTORE==0 at INSTART goes straight to DONE with INCNT=0 (one INNERDN pulse, zero iterations).
// TESTING
//  - Reset: RESETL low mid-RUN with INCNT=5 -> all outputs 0 immediately, state IDLE; no INNERDN after release.
//  - Loads: LDINRL low with D=0x03, next cycle LDSTPL low with D=0xFE, LDPATL low with D=0x5A
//    -> STEP=0xFE, PATTERN=0x5A; INSTART -> INCNT=3, INACT=1.
//  - Count: ISTORE=3, INSTART, then INSTEP on 3 edges
//    -> INCNT 3,2,1,0; INNERDN high one cycle after the 3rd; INACT low; back to IDLE; INSTART again reloads 3.
//  - Zero count: ISTORE=0, INSTART.
//    - With BLIT_INZERO256_EN: INCNT=256; 256 INSTEPs are needed for INNERDN.
//    - Without it: INNERDN the next cycle, INACT never high.
//  - Collisions:
//    - LDINRL (D=7) during RUN at INCNT=2: count still ends after 2 steps; next INSTART loads 7.
//    - INSTART+INSTEP in IDLE with ISTORE=4: INCNT=4.
//  - Ignored inputs: INSTART during RUN and INSTEP in IDLE/DONE -> INCNT and state unchanged.

Source files
------------

// File: rtl/blit_param_regs_if.sv
// Parameter-load and inner-loop handshake bundle between the blitter
// parameter sequencer and blit_param_regs.
interface blit_param_regs_if #(parameter int DW = 8);
  logic [DW-1:0] D;
  logic          LDINRL;
  logic          LDSTPL;
  logic          LDPATL;
  logic          INSTART;
  logic          INSTEP;
  logic [DW:0]   INCNT;
  logic          INACT;
  logic          INNERDN;
  logic [DW-1:0] STEP;
  logic [DW-1:0] PATTERN;

  modport master (
    output D, LDINRL, LDSTPL, LDPATL, INSTART, INSTEP,
    input  INCNT, INACT, INNERDN, STEP, PATTERN
  );

  modport slave (
    input  D, LDINRL, LDSTPL, LDPATL, INSTART, INSTEP,
    output INCNT, INACT, INNERDN, STEP, PATTERN
  );
endinterface

// File: rtl/blit_param_regs.sv
// Blitter parameter registers (inner count, step, pattern) and inner-loop counter.
// Optional macro BLIT_INZERO256_EN: a zero inner count runs a full 2^DW loop.
module blit_param_regs #(
  parameter int DW = 8
) (
  input  logic              CCLK,
  input  logic              RESETL,
  blit_param_regs_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DW:0] CNT_ONE = (DW+1)'(1);

  state_t        state, nxt_state;
  logic [DW-1:0] istore, step_q, pattern_q;
  logic [DW:0]   incnt, nxt_incnt;
  logic          inact, innerdn;

  always_comb begin
    nxt_state = state;
    nxt_incnt = incnt;
    unique case (state)
      IDLE: begin
        // INSTEP is deliberately not looked at here; a start never decrements
        if (bus.INSTART) begin
          nxt_incnt = {1'b0, istore};
          if (istore != '0) begin
            nxt_state = RUN;
          end else begin
`ifdef BLIT_INZERO256_EN
            nxt_incnt = {1'b1, {DW{1'b0}}};
            nxt_state = RUN;
`else
            nxt_state = DONE;
`endif
          end
        end
      end
      RUN: begin
        if (bus.INSTEP) begin
          if (incnt > CNT_ONE) begin
            nxt_incnt = incnt - CNT_ONE;
          end else begin
            nxt_incnt = '0;
            nxt_state = DONE;
          end
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Loads only touch istore, so a reload mid-run waits for the next INSTART
  always_ff @(posedge CCLK or negedge RESETL) begin
    if (!RESETL) begin
      state     <= IDLE;
      incnt     <= '0;
      istore    <= '0;
      step_q    <= '0;
      pattern_q <= '0;
      inact     <= 1'b0;
      innerdn   <= 1'b0;
    end else begin
      state   <= nxt_state;
      incnt   <= nxt_incnt;
      inact   <= (nxt_state == RUN);
      innerdn <= (nxt_state == DONE);
      if (!bus.LDINRL) istore    <= bus.D;
      if (!bus.LDSTPL) step_q    <= bus.D;
      if (!bus.LDPATL) pattern_q <= bus.D;
    end
  end

  assign bus.INCNT   = incnt;
  assign bus.INACT   = inact;
  assign bus.INNERDN = innerdn;
  assign bus.STEP    = step_q;
  assign bus.PATTERN = pattern_q;

endmodule

// File: tb/tb_blit_param_regs.sv
// Directed table-driven bench for blit_param_regs plus hand-written reset and
// zero-count sequences.
module tb_blit_param_regs;
  localparam int DW = 8;

  logic CCLK;
  logic RESETL;
  int   checks;
  int   errors;

  blit_param_regs_if #(.DW(DW)) bus ();

  blit_param_regs #(.DW(DW)) dut (
    .CCLK   (CCLK),
    .RESETL (RESETL),
    .bus    (bus)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  // Load fields are active-high here and inverted onto the active-low strobes
  typedef struct {
    logic          ld_in, ld_stp, ld_pat;
    logic [DW-1:0] d;
    logic          start, stp;
    logic [DW:0]   e_cnt;
    logic          e_act, e_dn;
    logic [DW-1:0] e_step, e_pat;
  } vec_t;

  vec_t tbl[38];

  function automatic vec_t v(logic li, logic ls, logic lp, logic [DW-1:0] d,
                             logic st, logic sp, logic [DW:0] c, logic a,
                             logic dn, logic [DW-1:0] s, logic [DW-1:0] p);
    vec_t r;
    r.ld_in = li; r.ld_stp = ls; r.ld_pat = lp; r.d = d;
    r.start = st; r.stp = sp;
    r.e_cnt = c; r.e_act = a; r.e_dn = dn; r.e_step = s; r.e_pat = p;
    return r;
  endfunction

  task automatic drive(logic li, logic ls, logic lp, logic [DW-1:0] d,
                       logic st, logic sp);
    bus.LDINRL  = ~li;
    bus.LDSTPL  = ~ls;
    bus.LDPATL  = ~lp;
    bus.D       = d;
    bus.INSTART = st;
    bus.INSTEP  = sp;
  endtask

  task automatic chk(string name, logic [DW:0] c, logic a, logic dn,
                     logic [DW-1:0] s, logic [DW-1:0] p);
    checks++;
    if (bus.INCNT !== c || bus.INACT !== a || bus.INNERDN !== dn ||
        bus.STEP !== s || bus.PATTERN !== p) begin
      errors++;
      $display("FAIL %s: got incnt=%0d inact=%b innerdn=%b step=%h pattern=%h, exp incnt=%0d inact=%b innerdn=%b step=%h pattern=%h",
               name, bus.INCNT, bus.INACT, bus.INNERDN, bus.STEP, bus.PATTERN,
               c, a, dn, s, p);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            li ls lp d      st sp cnt act dn step   pat
    tbl[0]  = v(1, 0, 0, 8'h03, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = v(0, 1, 0, 8'hFE, 0, 0, 0, 0, 0, 8'hFE, 8'h00);
    tbl[2]  = v(0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 8'hFE, 8'h5A);
    tbl[3]  = v(0, 0, 0, 8'h00, 1, 0, 3, 1, 0, 8'hFE, 8'h5A);
    tbl[4]  = v(0, 0, 0, 8'h00, 0, 1, 2, 1, 0, 8'hFE, 8'h5A);
    tbl[5]  = v(0, 0, 0, 8'h00, 1, 0, 2, 1, 0, 8'hFE, 8'h5A); // start in RUN
    tbl[6]  = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 8'h5A);
    tbl[7]  = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFE, 8'h5A);
    tbl[8]  = v(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'hFE, 8'h5A); // ignored in DONE
    tbl[9]  = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hFE, 8'h5A); // step in IDLE
    tbl[10] = v(0, 0, 0, 8'h00, 1, 0, 3, 1, 0, 8'hFE, 8'h5A);
    tbl[11] = v(0, 0, 0, 8'h00, 0, 1, 2, 1, 0, 8'hFE, 8'h5A);
    tbl[12] = v(1, 0, 0, 8'h07, 0, 0, 2, 1, 0, 8'hFE, 8'h5A); // reload in RUN
    tbl[13] = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 8'h5A);
    tbl[14] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFE, 8'h5A);
    tbl[15] = v(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFE, 8'h5A);
    tbl[16] = v(0, 0, 0, 8'h00, 1, 0, 7, 1, 0, 8'hFE, 8'h5A);
    tbl[17] = v(0, 0, 0, 8'h00, 0, 1, 6, 1, 0, 8'hFE, 8'h5A);
    tbl[18] = v(0, 0, 0, 8'h00, 0, 1, 5, 1, 0, 8'hFE, 8'h5A);
    tbl[19] = v(0, 0, 0, 8'h00, 0, 1, 4, 1, 0, 8'hFE, 8'h5A);
    tbl[20] = v(0, 0, 0, 8'h00, 0, 1, 3, 1, 0, 8'hFE, 8'h5A);
    tbl[21] = v(0, 0, 0, 8'h00, 0, 1, 2, 1, 0, 8'hFE, 8'h5A);
    tbl[22] = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 8'h5A);
    tbl[23] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFE, 8'h5A);
    tbl[24] = v(1, 0, 0, 8'h04, 0, 0, 0, 0, 0, 8'hFE, 8'h5A);
    tbl[25] = v(0, 0, 0, 8'h00, 1, 1, 4, 1, 0, 8'hFE, 8'h5A); // start+step
    tbl[26] = v(0, 0, 0, 8'h00, 0, 1, 3, 1, 0, 8'hFE, 8'h5A);
    tbl[27] = v(0, 0, 0, 8'h00, 0, 1, 2, 1, 0, 8'hFE, 8'h5A);
    tbl[28] = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 8'h5A);
    tbl[29] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFE, 8'h5A);
    tbl[30] = v(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFE, 8'h5A);
    tbl[31] = v(1, 0, 0, 8'h00, 1, 0, 4, 1, 0, 8'hFE, 8'h5A); // old ISTORE used
    tbl[32] = v(0, 0, 0, 8'h00, 0, 1, 3, 1, 0, 8'hFE, 8'h5A);
    tbl[33] = v(0, 0, 0, 8'h00, 0, 1, 2, 1, 0, 8'hFE, 8'h5A);
    tbl[34] = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 8'h5A);
    tbl[35] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFE, 8'h5A);
    tbl[36] = v(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFE, 8'h5A);
    tbl[37] = v(0, 1, 1, 8'h11, 0, 0, 0, 0, 0, 8'h11, 8'h11); // dual load

    RESETL = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0);
    repeat (2) @(negedge CCLK);
    chk("reset_state", 0, 0, 0, 8'h00, 8'h00);
    RESETL = 1'b1;

    for (int i = 0; i < 38; i++) begin
      drive(tbl[i].ld_in, tbl[i].ld_stp, tbl[i].ld_pat, tbl[i].d,
            tbl[i].start, tbl[i].stp);
      @(negedge CCLK);
      chk($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_act, tbl[i].e_dn,
          tbl[i].e_step, tbl[i].e_pat);
    end

    // Zero inner count (ISTORE is 0 after vec31)
    drive(0, 0, 0, 8'h00, 1, 0);
    @(negedge CCLK);
`ifdef BLIT_INZERO256_EN
    chk("zero_start", 9'd256, 1, 0, 8'h11, 8'h11);
    drive(0, 0, 0, 8'h00, 0, 1);
    repeat (255) @(negedge CCLK);
    chk("zero_255", 9'd1, 1, 0, 8'h11, 8'h11);
    @(negedge CCLK);
    chk("zero_done", 0, 0, 1, 8'h11, 8'h11);
`else
    chk("zero_done", 0, 0, 1, 8'h11, 8'h11);
    drive(0, 0, 0, 8'h00, 0, 0);
    @(negedge CCLK);
    chk("zero_idle", 0, 0, 0, 8'h11, 8'h11);
`endif
    drive(0, 0, 0, 8'h00, 0, 0);
    @(negedge CCLK);

    // Async reset mid-RUN at INCNT=5
    drive(1, 0, 0, 8'h05, 0, 0);
    @(negedge CCLK);
    drive(0, 0, 0, 8'h00, 1, 0);
    @(negedge CCLK);
    chk("run5", 5, 1, 0, 8'h11, 8'h11);
    drive(0, 0, 0, 8'h00, 0, 0);
    #2 RESETL = 1'b0;
    #1 chk("reset_async", 0, 0, 0, 8'h00, 8'h00);
    @(negedge CCLK);
    RESETL = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CCLK);
      chk($sformatf("post_reset%0d", i), 0, 0, 0, 8'h00, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
